// File: rtl/frv_leak_seq_pkg.sv
// Shared definitions for the leakage-fence scrub sequencer: FSM encoding,
// resource count and index width.
package frv_leak_seq_pkg;

    localparam int NRES_DEF = 13;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/frv_leak_penc.sv
// Lowest-set-bit priority encoder: index of the first pending resource plus
// a flag saying whether any resource is pending at all.
module frv_leak_penc
    import frv_leak_seq_pkg::*;
#(
    parameter int NRES = NRES_DEF
) (
    input  logic [NRES-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NRES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frv_leak_seq.sv
// Leakage-fence sequencer: snapshots the scrub mask on a fence, issues one
// scrub request per enabled resource (lowest index first), then acks once.
//
// Scrub handshake: a request transfers on a cycle where clr_valid and
// clr_ready are both high; while clr_valid is high and clr_ready is low,
// clr_idx and clr_data hold stable, and clr_valid never drops before transfer.
module frv_leak_seq
    import frv_leak_seq_pkg::*;
#(
    parameter int   XLEN                 = 32,
    parameter logic XC_CLASS_LEAK_STRONG = 1'b1,
    parameter int   NRES                 = NRES_DEF
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             fence_req,
    output logic             fence_ack,
    input  logic [NRES-1:0]  leak_lkgcfg,
    input  logic [XLEN-1:0]  leak_prng,
    output logic             leak_fence,
    output logic             seq_busy,
    output logic             clr_valid,
    output logic [IDX_W-1:0] clr_idx,
    output logic [XLEN-1:0]  clr_data,
    input  logic             clr_ready,
    output logic [1:0]       dbg_state
);

    localparam int XL = XLEN - 1;

    seq_state_t       state_q, state_d;
    logic [NRES-1:0]  mask_q, mask_d, mask_clr;
    logic [IDX_W-1:0] pidx;
    logic             pany;
    logic             hs;
    logic [XL:0]      scrub_word;

    frv_leak_penc #(.NRES(NRES)) u_penc (
        .req (mask_q),
        .idx (pidx),
        .any (pany)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    assign mask_clr = mask_q & ~(NRES'(1) << pidx);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (fence_req) begin
                    mask_d  = leak_lkgcfg;
                    state_d = (|leak_lkgcfg) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (!pany) begin
                    state_d = ST_DONE;
                end else if (hs) begin
                    mask_d = mask_clr;
                    if (mask_clr == '0) state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so nothing escapes while the FSM is held.
    assign scrub_word = XC_CLASS_LEAK_STRONG ? leak_prng : '0;
    assign clr_valid  = g_resetn & (state_q == ST_ISSUE) & pany;
    assign hs         = clr_valid & clr_ready;
    assign clr_idx    = clr_valid ? pidx : '0;
    assign clr_data   = clr_valid ? scrub_word : '0;
    assign leak_fence = hs & XC_CLASS_LEAK_STRONG;
    assign fence_ack  = g_resetn & (state_q == ST_DONE);
    assign seq_busy   = g_resetn ? ((state_q != ST_IDLE) | fence_req) : fence_req;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_frv_leak_seq.sv
// Scoreboard bench for frv_leak_seq: a STRONG and a weak instance share the
// stimulus; the bench owns the PRNG (a 32-bit LFSR advanced on leak_fence).
module tb_frv_leak_seq;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        fence_req = 1'b0;
    logic        clr_ready = 1'b1;
    logic [12:0] lkgcfg = 13'h0;
    logic [31:0] prng = 32'hABCDEF37;

    logic        s_ack, s_lf, s_busy, s_valid;
    logic [3:0]  s_idx;
    logic [31:0] s_data;
    logic [1:0]  s_state;
    logic        w_ack, w_lf, w_busy, w_valid;
    logic [3:0]  w_idx;
    logic [31:0] w_data;
    logic [1:0]  w_state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_req = 0;
    int pulses = 0, w_pulses = 0, valids = 0, w_valids = 0, acks = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_ent;

    frv_leak_seq #(.XLEN(32), .XC_CLASS_LEAK_STRONG(1'b1), .NRES(13)) dut_s (
        .g_clk(g_clk), .g_resetn(g_resetn), .fence_req(fence_req), .fence_ack(s_ack),
        .leak_lkgcfg(lkgcfg), .leak_prng(prng), .leak_fence(s_lf), .seq_busy(s_busy),
        .clr_valid(s_valid), .clr_idx(s_idx), .clr_data(s_data), .clr_ready(clr_ready),
        .dbg_state(s_state)
    );

    frv_leak_seq #(.XLEN(32), .XC_CLASS_LEAK_STRONG(1'b0), .NRES(13)) dut_w (
        .g_clk(g_clk), .g_resetn(g_resetn), .fence_req(fence_req), .fence_ack(w_ack),
        .leak_lkgcfg(lkgcfg), .leak_prng(prng), .leak_fence(w_lf), .seq_busy(w_busy),
        .clr_valid(w_valid), .clr_idx(w_idx), .clr_data(w_data), .clr_ready(clr_ready),
        .dbg_state(w_state)
    );

    // ---------------- clock / PRNG model ----------------
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    always @(posedge g_clk) if (s_lf) prng <= lfsr_next(prng);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (s_valid && clr_ready) begin
                check("q_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_ent = exp_q.pop_front();
                    check("scrub_idx", 64'(s_idx), 64'(mon_ent[35:32]));
                    check("scrub_data", 64'(s_data), 64'(mon_ent[31:0]));
                end
            end
            if (w_valid && clr_ready) check("weak_data", 64'(w_data), 64'd0);
            pulses   += int'(s_lf);
            w_pulses += int'(w_lf);
            valids   += int'(s_valid);
            w_valids += int'(w_valid);
            acks     += int'(s_ack);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge g_clk);
        #2;
    endtask

    task automatic push_exp(input logic [12:0] cfg);
        logic [31:0] m;
        m = prng;
        for (int i = 0; i < 13; i++) begin
            if (cfg[i]) begin
                exp_q.push_back({4'(i), m});
                m = lfsr_next(m);
            end
        end
    endtask

    task automatic start_fence(input logic [12:0] cfg);
        tick();
        push_exp(cfg);
        lkgcfg    = cfg;
        fence_req = 1'b1;
        t_req     = cyc;
    endtask

    // Latency = rising edges from request assertion to the edge capturing ack.
    task automatic wait_ack(input int exp_lat, input string tag, input bit hold);
        int lat;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge g_clk);
            if (s_ack) begin
                lat = cyc + 1 - t_req;
                break;
            end
        end
        check({tag, "_ack_lat"}, 64'(lat), 64'(exp_lat));
        tick();
        if (hold) t_req = cyc;
        else fence_req = 1'b0;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bp, bv, ba, bwv;
        logic [31:0] d0;

        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check("rst_state", 64'(s_state), 64'd0);
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_ack", 64'(s_ack), 64'd0);
        check("rst_lf", 64'(s_lf), 64'd0);
        check("rst_idx", 64'(s_idx), 64'd0);
        check("rst_data", 64'(s_data), 64'd0);
        check("rst_busy", 64'(s_busy), 64'd0);
        tick();
        g_resetn = 1'b1;

        // T1: two resources, ready tied high
        bp = pulses; ba = acks;
        start_fence(13'h0005);
        wait_ack(4, "t1", 1'b0);
        settle();
        check("t1_pulses", 64'(pulses - bp), 64'd2);
        check("t1_acks", 64'(acks - ba), 64'd1);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // T2: empty mask
        bp = pulses; bv = valids;
        start_fence(13'h0000);
        wait_ack(2, "t2", 1'b0);
        settle();
        check("t2_valids", 64'(valids - bv), 64'd0);
        check("t2_pulses", 64'(pulses - bp), 64'd0);

        // T3: back-pressure for three cycles on the first request
        ba = acks; bp = pulses;
        clr_ready = 1'b0;
        d0 = prng;
        start_fence(13'h1001);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            check("t3_hold_valid", 64'(s_valid), 64'd1);
            check("t3_hold_idx", 64'(s_idx), 64'd0);
            check("t3_hold_data", 64'(s_data), 64'(d0));
            check("t3_hold_busy", 64'(s_busy), 64'd1);
            tick();
        end
        clr_ready = 1'b1;
        wait_ack(7, "t3", 1'b0);
        settle();
        check("t3_acks", 64'(acks - ba), 64'd1);
        check("t3_pulses", 64'(pulses - bp), 64'd2);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // T4: config changes after the snapshot
        bv = valids;
        start_fence(13'h0002);
        tick();
        lkgcfg = 13'h1FFF;
        wait_ack(3, "t4", 1'b0);
        settle();
        check("t4_valids", 64'(valids - bv), 64'd1);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // All thirteen resources
        bp = pulses;
        start_fence(13'h1FFF);
        wait_ack(15, "full", 1'b0);
        settle();
        check("full_pulses", 64'(pulses - bp), 64'd13);
        check("full_q_empty", 64'(exp_q.size()), 64'd0);

        // T5: reset during the second ISSUE cycle
        ba = acks;
        start_fence(13'h0007);
        tick();
        tick();
        g_resetn  = 1'b0;
        fence_req = 1'b0;
        @(negedge g_clk);
        check("t5_busy_in_rst", 64'(s_busy), 64'd0);
        tick();
        g_resetn = 1'b1;
        exp_q.delete();
        @(negedge g_clk);
        check("t5_state", 64'(s_state), 64'd0);
        check("t5_valid", 64'(s_valid), 64'd0);
        check("t5_ack", 64'(s_ack), 64'd0);
        settle();
        check("t5_acks", 64'(acks - ba), 64'd0);

        // T6: weak instance scrubs with zero and never advances the PRNG
        bwv = w_valids; bp = w_pulses;
        start_fence(13'h0003);
        wait_ack(4, "t6", 1'b0);
        settle();
        check("t6_weak_valids", 64'(w_valids - bwv), 64'd2);
        check("t6_weak_pulses", 64'(w_pulses - bp), 64'd0);

        // T7: request held through the ack starts a second fence
        ba = acks;
        start_fence(13'h0000);
        wait_ack(2, "t7a", 1'b1);
        wait_ack(2, "t7b", 1'b0);
        settle();
        check("t7_acks", 64'(acks - ba), 64'd2);

        check("weak_pulses_total", 64'(w_pulses), 64'd0);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
